videogen_scroll: RTL and testbench
==================================

Name: videogen_scroll

Overview:
- Parametrised successor to the fixed 720x480 noise/latency pattern generator.
- Generates programmable-timing sync, DE and 24-bit RGB, with four frame-latched pattern modes, including LFSR noise that scrolls vertically at a programmable rate.
- Sits between the 27 MHz clock source and the video DAC/HDMI transmitter; it is the only pixel source in the design.

Parameters:
- H_SYNCLEN, 62, hsync width in pixels
- H_BACKPORCH, 60, pixels between hsync end and active start
- H_ACTIVE, 720, active pixels per line; must be a multiple of 8
- H_TOTAL, 858, pixels per line
- V_SYNCLEN, 6, vsync width in lines
- V_BACKPORCH, 30, lines between vsync end and active start
- V_ACTIVE, 480, active lines
- V_TOTAL, 525, lines per frame
- CNT_W, 11, h/v counter width; must satisfy 2^CNT_W > H_TOTAL
- LFSR_SEED, 16'hACE1, nonzero LFSR reset seed

Ports:
- clk27  in  1  pixel clock
- reset_n  in  1  async active-low reset
- mode  in  2  0=black, 1=1px checkerboard, 2=8 colour bars, 3=scrolling noise
- scroll_speed  in  4  noise scroll rate in lines per frame; 0 = static
- R_out, G_out, B_out  out  8 each  pixel data; 0 whenever ENABLE_out=0
- HSYNC_out  out  1  negative polarity
- VSYNC_out  out  1  negative polarity
- PCLK_out  out  1  equals clk27
- ENABLE_out  out  1  active-video DE
- frame_start  out  1  one-cycle pulse, first cycle of each frame

Behaviour:
- Clock/reset: one clock, clk27; reset_n is asynchronous, active-low.
- Reset values: h_cnt=v_cnt=0; HSYNC_out=0, VSYNC_out=0, ENABLE_out=0, RGB=0, frame_start=0; mode latch=0; all LFSRs=LFSR_SEED.
- Counters:
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments when h_cnt==H_TOTAL-1 and wraps V_TOTAL-1 -> 0.
- Timing outputs: registered, 1-cycle latency from the counters.
  - HSYNC_out=0 iff h_cnt<H_SYNCLEN.
  - VSYNC_out=0 iff v_cnt<V_SYNCLEN.
  - ENABLE_out=1 iff X_START<=h_cnt<X_START+H_ACTIVE and Y_START<=v_cnt<Y_START+V_ACTIVE, where X_START=H_SYNCLEN+H_BACKPORCH and Y_START=V_SYNCLEN+V_BACKPORCH.
  - frame_start=1 for the cycle after h_cnt==0 and v_cnt==0.
- Data path: RGB is registered in the same cycle as ENABLE_out, so DE and data stay aligned.
- Mode latch: mode and scroll_speed are sampled only at h_cnt==H_TOTAL-1 on v_cnt==V_TOTAL-1. A mid-frame change never tears the image.
- Mode 0: RGB=0.
- Mode 1: gray = (h_cnt[0]^v_cnt[0]) ? FF : 00.
- Mode 2: colour bars.
  - A bar counter (0..7) advances every H_ACTIVE/8 active pixels and resets at X_START.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black. Component levels are BF/00.
- Mode 3: scrolling noise.
  - Three 16-bit Fibonacci LFSRs (frame_seed, line_seed, pix), all with taps 15,14,12,3, shift left, feedback into bit 0.
  - frame_seed steps once per line at h_cnt==H_TOTAL-1 while v_cnt<min(scroll_speed, Y_START).
  - At h_cnt==H_TOTAL-1 on v_cnt==Y_START-1, line_seed loads frame_seed. On each subsequent active line's last cycle, line_seed steps once.
  - At h_cnt==X_START-1, pix loads line_seed; pix then steps every active cycle.
  - gray = pix[7:0].
  - Result: active row r of frame n+1 equals row r+scroll_speed of frame n, i.e. the image scrolls upward.
- All LFSRs hold when mode!=3.
- LFSR lock-up: an all-zero state is unreachable from a nonzero seed. If it is detected anyway, reload LFSR_SEED.

Optional Feature:
- Macro: VIDEOGEN_SCROLL_COLOR_NOISE_EN.
- Defined: mode 3 drives R=pix[7:0], G=pix[15:8], B=line_seed[7:0].
- Undefined: R=G=B=pix[7:0] (grayscale).
- All other modes are identical either way.

Test Plan:
- Release reset, default params -> HSYNC_out low 62 cycles per 858, VSYNC_out low 6 lines per 525, ENABLE_out high exactly 720x480 cycles per frame, first DE at h_cnt=123 of v_cnt=36, frame_start every 450450 cycles.
- mode=1 -> active pixels alternate FF/00 along x and y; RGB=0 for every cycle with ENABLE_out=0.
- mode=2 -> 8 bars of exactly 90 pixels each; first pixel BF/BF/BF, pixel 630 is 00/00/00.
- mode=3, scroll_speed=0 -> two consecutive frames bit-identical. scroll_speed=4 -> frame n+1 row 0 equals frame n row 4.
- Change mode 2->3 mid-frame at v_cnt=200 -> the rest of that frame is still bars; noise starts on the next frame.
- Assert reset_n low at h_cnt=400, v_cnt=100 -> all outputs 0 asynchronously; after release, timing restarts from h_cnt=0, v_cnt=0 and the noise image matches a post-power-up frame.

Source files
------------

// File: rtl/videogen_scroll.sv
// videogen_scroll: programmable-timing video pattern generator.
// Produces negative-polarity sync, DE and 24-bit RGB with four frame-latched
// modes: black, 1px checkerboard, 8 colour bars, vertically scrolling LFSR noise.
// Optional build macro VIDEOGEN_SCROLL_COLOR_NOISE_EN: when defined, mode 3
// drives colour noise (R=pix[7:0], G=pix[15:8], B=line_seed[7:0]); when
// undefined, mode 3 is grayscale noise (R=G=B=pix[7:0]).
module videogen_scroll #(
  parameter int          H_SYNCLEN   = 62,
  parameter int          H_BACKPORCH = 60,
  parameter int          H_ACTIVE    = 720,
  parameter int          H_TOTAL     = 858,
  parameter int          V_SYNCLEN   = 6,
  parameter int          V_BACKPORCH = 30,
  parameter int          V_ACTIVE    = 480,
  parameter int          V_TOTAL     = 525,
  parameter int          CNT_W       = 11,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk27,
  input  logic       reset_n,
  input  logic [1:0] mode,
  input  logic [3:0] scroll_speed,
  output logic [7:0] R_out,
  output logic [7:0] G_out,
  output logic [7:0] B_out,
  output logic       HSYNC_out,
  output logic       VSYNC_out,
  output logic       PCLK_out,
  output logic       ENABLE_out,
  output logic       frame_start
);

  localparam int X_START = H_SYNCLEN + H_BACKPORCH;
  localparam int Y_START = V_SYNCLEN + V_BACKPORCH;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_SYNCLEN);
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_SYNCLEN);
  localparam logic [CNT_W-1:0] X_START_C  = CNT_W'(X_START);
  localparam logic [CNT_W-1:0] X_END_C    = CNT_W'(X_START + H_ACTIVE);
  localparam logic [CNT_W-1:0] X_PRE_C    = CNT_W'(X_START - 1);
  localparam logic [CNT_W-1:0] Y_START_C  = CNT_W'(Y_START);
  localparam logic [CNT_W-1:0] Y_END_C    = CNT_W'(Y_START + V_ACTIVE);
  localparam logic [CNT_W-1:0] Y_PRE_C    = CNT_W'(Y_START - 1);
  localparam logic [CNT_W-1:0] BAR_LAST_C = CNT_W'(H_ACTIVE / 8 - 1);

  // One Fibonacci step (taps 15,14,12,3); an all-zero state reloads the seed.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    if (s == 16'h0000) begin
      n = LFSR_SEED;
    end else begin
      n = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    end
    return n;
  endfunction

  logic [CNT_W-1:0] h_cnt_r, v_cnt_r, bar_sub_r, speed_ext_s;
  logic [2:0]       bar_idx_r;
  logic [1:0]       mode_r;
  logic [3:0]       speed_r;
  logic [15:0]      frame_seed_r, line_seed_r, pix_lfsr_r;
  logic             h_last_s, v_last_s, x_act_s, y_act_s, de_s, noise_s;
  logic [7:0]       red_s, grn_s, blu_s, gray_s;

  assign h_last_s    = (h_cnt_r == H_LAST_C);
  assign v_last_s    = (v_cnt_r == V_LAST_C);
  assign x_act_s     = (h_cnt_r >= X_START_C) && (h_cnt_r < X_END_C);
  assign y_act_s     = (v_cnt_r >= Y_START_C) && (v_cnt_r < Y_END_C);
  assign de_s        = x_act_s && y_act_s;
  assign noise_s     = (mode_r == 2'd3);
  assign speed_ext_s = CNT_W'(speed_r);
  assign gray_s      = (h_cnt_r[0] ^ v_cnt_r[0]) ? 8'hFF : 8'h00;
  assign PCLK_out    = clk27;

  // Horizontal/vertical raster counters.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (h_last_s) begin
      h_cnt_r <= '0;
      v_cnt_r <= v_last_s ? '0 : v_cnt_r + CNT_ONE;
    end else begin
      h_cnt_r <= h_cnt_r + CNT_ONE;
    end
  end

  // Latch mode and scroll rate on the last cycle of the frame so frames never tear.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      mode_r  <= 2'd0;
      speed_r <= 4'd0;
    end else if (h_last_s && v_last_s) begin
      mode_r  <= mode;
      speed_r <= scroll_speed;
    end
  end

  // Colour bar index: cleared outside the active span, advances every H_ACTIVE/8 pixels.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      bar_idx_r <= 3'd0;
      bar_sub_r <= '0;
    end else if (!x_act_s) begin
      bar_idx_r <= 3'd0;
      bar_sub_r <= '0;
    end else if (bar_sub_r == BAR_LAST_C) begin
      bar_idx_r <= bar_idx_r + 3'd1;
      bar_sub_r <= '0;
    end else begin
      bar_sub_r <= bar_sub_r + CNT_ONE;
    end
  end

  // Noise LFSRs: frame seed advances scroll_speed lines per frame, line seed per active
  // line, pixel LFSR per active pixel; everything holds outside mode 3.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      frame_seed_r <= LFSR_SEED;
      line_seed_r  <= LFSR_SEED;
      pix_lfsr_r   <= LFSR_SEED;
    end else if (noise_s) begin
      if (h_last_s && (v_cnt_r < Y_START_C) && (v_cnt_r < speed_ext_s)) begin
        frame_seed_r <= lfsr_step(frame_seed_r);
      end
      if (h_last_s && (v_cnt_r == Y_PRE_C)) begin
        line_seed_r <= frame_seed_r;
      end else if (h_last_s && y_act_s) begin
        line_seed_r <= lfsr_step(line_seed_r);
      end
      if (h_cnt_r == X_PRE_C) begin
        pix_lfsr_r <= line_seed_r;
      end else if (de_s) begin
        pix_lfsr_r <= lfsr_step(pix_lfsr_r);
      end
    end
  end

  // Pixel colour for the current raster position and latched mode.
  always_comb begin
    red_s = 8'h00;
    grn_s = 8'h00;
    blu_s = 8'h00;
    case (mode_r)
      2'd0: begin
        red_s = 8'h00;
        grn_s = 8'h00;
        blu_s = 8'h00;
      end
      2'd1: begin
        red_s = gray_s;
        grn_s = gray_s;
        blu_s = gray_s;
      end
      2'd2: begin
        red_s = bar_idx_r[1] ? 8'h00 : 8'hBF;
        grn_s = bar_idx_r[2] ? 8'h00 : 8'hBF;
        blu_s = bar_idx_r[0] ? 8'h00 : 8'hBF;
      end
      2'd3: begin
`ifdef VIDEOGEN_SCROLL_COLOR_NOISE_EN
        red_s = pix_lfsr_r[7:0];
        grn_s = pix_lfsr_r[15:8];
        blu_s = line_seed_r[7:0];
`else
        red_s = pix_lfsr_r[7:0];
        grn_s = pix_lfsr_r[7:0];
        blu_s = pix_lfsr_r[7:0];
`endif
      end
      default: begin
        red_s = 8'h00;
        grn_s = 8'h00;
        blu_s = 8'h00;
      end
    endcase
  end

  // Registered sync, DE, frame pulse and RGB, all one cycle behind the counters.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      HSYNC_out   <= 1'b0;
      VSYNC_out   <= 1'b0;
      ENABLE_out  <= 1'b0;
      frame_start <= 1'b0;
      R_out       <= 8'h00;
      G_out       <= 8'h00;
      B_out       <= 8'h00;
    end else begin
      HSYNC_out   <= (h_cnt_r >= HS_END_C);
      VSYNC_out   <= (v_cnt_r >= VS_END_C);
      ENABLE_out  <= de_s;
      frame_start <= (h_cnt_r == '0) && (v_cnt_r == '0);
      R_out       <= de_s ? red_s : 8'h00;
      G_out       <= de_s ? grn_s : 8'h00;
      B_out       <= de_s ? blu_s : 8'h00;
    end
  end

endmodule

// File: tb/tb_videogen_scroll.sv
// Self-checking bench for videogen_scroll using a small raster so whole frames
// can be simulated; expected output is recomputed from raster arithmetic.
module tb_videogen_scroll;

  localparam int HS = 4, HBP = 4, HA = 16, HT = 28;
  localparam int VS = 2, VBP = 15, VA = 6, VT = 26;
  localparam int XS = HS + HBP, YS = VS + VBP, BW = HA / 8;
  localparam int FRAME = HT * VT;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    logic [1:0] mode_a;
    logic [3:0] speed_a;
    int         chg_v;
    logic [1:0] mode_b;
    logic [3:0] speed_b;
  } plan_t;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } bar_t;

  logic       clk27 = 1'b0;
  logic       reset_n;
  logic [1:0] mode;
  logic [3:0] scroll_speed;
  logic [7:0] R_out, G_out, B_out;
  logic       HSYNC_out, VSYNC_out, PCLK_out, ENABLE_out, frame_start;

  int checks = 0, failures = 0, pos = 0;
  plan_t plan [0:23];
  bar_t  bar_tab [0:7];
  logic [15:0] f_seed;
  logic [1:0]  cur_mode, pend_mode;
  logic [3:0]  cur_speed, pend_speed;

  videogen_scroll #(
    .H_SYNCLEN(HS), .H_BACKPORCH(HBP), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNCLEN(VS), .V_BACKPORCH(VBP), .V_ACTIVE(VA), .V_TOTAL(VT),
    .CNT_W(6), .LFSR_SEED(SEED)
  ) dut (
    .clk27(clk27), .reset_n(reset_n), .mode(mode), .scroll_speed(scroll_speed),
    .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .HSYNC_out(HSYNC_out), .VSYNC_out(VSYNC_out), .PCLK_out(PCLK_out),
    .ENABLE_out(ENABLE_out), .frame_start(frame_start)
  );

  always #5 clk27 = ~clk27;

  function automatic logic [15:0] step1(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
  endfunction

  function automatic logic [15:0] stepn(input logic [15:0] s, input int n);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = step1(t);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s pos=%0d actual=%0h required=%0h", name, pos, act, exp);
    end
  endtask

  task automatic model_reset();
    f_seed = SEED; cur_mode = 2'd0; cur_speed = 4'd0; pend_mode = 2'd0; pend_speed = 4'd0;
  endtask

  task automatic run_frames(input int first, input int nframes, input int rst_pos);
    int h, v, f, de_cnt, nsteps;
    bit done;
    bit de_e;
    plan_t pl;
    logic [15:0] val;
    logic [7:0] er, eg, eb;
    de_cnt = 0;
    done = 1'b0;
    for (int p = 0; p < nframes * FRAME && !done; p++) begin
      pos = p;
      h = p % HT; v = (p / HT) % VT; f = p / FRAME;
      pl = plan[first + f];
      if (v < pl.chg_v) begin
        mode = pl.mode_a; scroll_speed = pl.speed_a;
      end else begin
        mode = pl.mode_b; scroll_speed = pl.speed_b;
      end
      if (h == 0 && v == 0 && p != 0) begin
        chk("de_per_frame", 32'(de_cnt), 32'(HA * VA));
        de_cnt = 0;
        cur_mode = pend_mode; cur_speed = pend_speed;
      end
      if (h == 0 && v == 0 && cur_mode == 2'd3) begin
        nsteps = (int'(cur_speed) < YS) ? int'(cur_speed) : YS;
        f_seed = stepn(f_seed, nsteps);
      end
      if (h == HT - 1 && v == VT - 1) begin
        pend_mode = mode; pend_speed = scroll_speed;
      end
      @(posedge clk27);
      #1;
      de_e = (h >= XS) && (h < XS + HA) && (v >= YS) && (v < YS + VA);
      er = 8'h00; eg = 8'h00; eb = 8'h00;
      if (de_e) begin
        case (cur_mode)
          2'd1: begin
            er = (((h ^ v) & 1) != 0) ? 8'hFF : 8'h00; eg = er; eb = er;
          end
          2'd2: begin
            er = bar_tab[(h - XS) / BW].r; eg = bar_tab[(h - XS) / BW].g; eb = bar_tab[(h - XS) / BW].b;
          end
          2'd3: begin
            val = stepn(f_seed, (v - YS) + (h - XS));
            er = val[7:0];
`ifdef VIDEOGEN_SCROLL_COLOR_NOISE_EN
            eg = val[15:8];
            val = stepn(f_seed, v - YS);
            eb = val[7:0];
`else
            eg = val[7:0]; eb = val[7:0];
`endif
          end
          default: begin
            er = 8'h00; eg = 8'h00; eb = 8'h00;
          end
        endcase
      end
      chk("timing", 32'({HSYNC_out, VSYNC_out, ENABLE_out, frame_start}),
          32'({h >= HS, v >= VS, de_e, (h == 0) && (v == 0)}));
      chk("rgb", 32'({R_out, G_out, B_out}), 32'({er, eg, eb}));
      if (ENABLE_out) de_cnt++;
      if (p == rst_pos) begin
        #1 reset_n = 1'b0;
        #1 chk("async_reset", 32'({R_out, G_out, B_out, HSYNC_out, VSYNC_out, ENABLE_out, frame_start}), 32'd0);
        repeat (2) @(posedge clk27);
        #1 chk("reset_hold", 32'({R_out, G_out, B_out, HSYNC_out, VSYNC_out, ENABLE_out, frame_start}), 32'd0);
        reset_n = 1'b1;
        model_reset();
        done = 1'b1;
      end
    end
  endtask

  initial begin
    bar_tab[0] = '{8'hBF, 8'hBF, 8'hBF};  // white
    bar_tab[1] = '{8'hBF, 8'hBF, 8'h00};  // yellow
    bar_tab[2] = '{8'h00, 8'hBF, 8'hBF};  // cyan
    bar_tab[3] = '{8'h00, 8'hBF, 8'h00};  // green
    bar_tab[4] = '{8'hBF, 8'h00, 8'hBF};  // magenta
    bar_tab[5] = '{8'hBF, 8'h00, 8'h00};  // red
    bar_tab[6] = '{8'h00, 8'h00, 8'hBF};  // blue
    bar_tab[7] = '{8'h00, 8'h00, 8'h00};  // black

    // Inputs driven during frame i take effect in frame i+1.
    plan[0] = '{2'd1, 4'd0, VT, 2'd1, 4'd0};   // checkerboard next
    plan[1] = '{2'd2, 4'd0, VT, 2'd2, 4'd0};   // bars next
    plan[2] = '{2'd2, 4'd0, 10, 2'd3, 4'd0};   // mid-frame switch to noise
    plan[3] = '{2'd3, 4'd0, VT, 2'd3, 4'd0};   // static noise repeat
    plan[4] = '{2'd3, 4'd4, VT, 2'd3, 4'd4};   // scroll by 4
    plan[5] = '{2'd3, 4'd4, VT, 2'd3, 4'd4};
    plan[6] = '{2'd3, 4'd15, VT, 2'd3, 4'd15};
    plan[7] = '{2'd0, 4'd0, VT, 2'd0, 4'd0};
    for (int i = 8; i < 18; i++) begin
      plan[i].mode_a  = 2'($urandom_range(0, 3));
      plan[i].speed_a = 4'($urandom_range(0, 15));
      plan[i].chg_v   = int'($urandom_range(0, VT));
      plan[i].mode_b  = 2'($urandom_range(0, 3));
      plan[i].speed_b = 4'($urandom_range(0, 15));
    end
    plan[18] = '{2'd3, 4'd3, VT, 2'd3, 4'd3};
    plan[19] = '{2'd1, 4'd0, VT, 2'd1, 4'd0};
    plan[20] = '{2'd3, 4'd2, VT, 2'd3, 4'd2};
    plan[21] = '{2'd3, 4'd2, VT, 2'd3, 4'd2};
    plan[22] = '{2'd3, 4'd0, VT, 2'd3, 4'd0};
    plan[23] = '{2'd0, 4'd0, VT, 2'd0, 4'd0};

    reset_n = 1'b0; mode = 2'd0; scroll_speed = 4'd0;
    model_reset();
    repeat (3) @(posedge clk27);
    #1;
    chk("reset", 32'({R_out, G_out, B_out, HSYNC_out, VSYNC_out, ENABLE_out, frame_start}), 32'd0);
    chk("pclk", 32'(PCLK_out), 32'(clk27));
    reset_n = 1'b1;

    // Nineteen full frames, then reset mid-active-area in frame 19 (v=19, h=10).
    run_frames(0, 20, 19 * FRAME + 19 * HT + 10);
    // Restart after reset: timing and noise must begin exactly as after power-up.
    run_frames(20, 4, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
